// File: rtl/math_round_sat_49_pkg.sv
// math_round_sat_49_pkg: shared sum/intermediate widths, output FIFO depth and clamp-bound helper
package math_round_sat_49_pkg;
  localparam int SUM_W = 49;
  localparam int INT_W = 50;
  localparam int FIFO_DEPTH = 4;
  function automatic logic [INT_W-1:0] clamp_bound(input int ow, input bit sgn, input bit hi);
    logic [INT_W-1:0] m;
    m = INT_W'(1) << (sgn ? ow - 1 : ow);
    return hi ? m - INT_W'(1) : (sgn ? -m : '0);
  endfunction
endpackage

// File: rtl/math_round_sat_49_fifo.sv
// math_fifo_4: 4-entry output FIFO (clk/rst/ena, push/wdata in, pop/rdata out, count; pop before push when full)
module math_fifo_4
  import math_round_sat_49_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [2:0]   count
);
  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0] rptr, wptr;
  logic do_pop, do_push;
  assign do_pop = ena && pop && count != 3'd0;
  assign do_push = ena && push && (count != 3'(FIFO_DEPTH) || do_pop);
  assign rdata = count != 3'd0 ? mem[rptr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr <= wptr + 2'd1;
      end
      if (do_pop) rptr <= rptr + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end
endmodule

// File: rtl/math_round_sat_49.sv
// math_round_sat_49: round-half-up + clamp of 49-bit sums into a 4-deep FIFO (din/din_valid/din_ready in, dout/dout_valid/dout_ready out, sticky sat_flag/drop_flag; MATH_ROUND_SAT_STATS_EN adds sat_count)
module math_round_sat_49
  import math_round_sat_49_pkg::*;
#(
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT = 16,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [SUM_W-1:0]     din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 sat_flag,
  output logic                 drop_flag
`ifdef MATH_ROUND_SAT_STATS_EN
  ,
  output logic [15:0]          sat_count
`endif
);
  localparam logic [INT_W-1:0] RC = SHIFT == 0 ? '0 : INT_W'(1) << (SHIFT == 0 ? 0 : SHIFT - 1);
  localparam logic [INT_W-1:0] HI = clamp_bound(OUT_WIDTH, SIGNED != 0, 1'b1);
  localparam logic [INT_W-1:0] LO = clamp_bound(OUT_WIDTH, SIGNED != 0, 1'b0);
  logic [INT_W-1:0] sum, rnd, s1_data;
  logic signed [INT_W-1:0] rnd_s;
  logic [OUT_WIDTH-1:0] clamped;
  logic [2:0] count;
  logic s1_valid, in_xfer, over, under, sat;
  assign sum = (SIGNED != 0 ? {{2{din[47]}}, din[47:0]} : {1'b0, din}) + RC;
  assign rnd_s = $signed(sum) >>> SHIFT;
  assign rnd = SIGNED != 0 ? rnd_s : sum >> SHIFT;
  assign over = SIGNED != 0 ? $signed(s1_data) > $signed(HI) : s1_data > HI;
  assign under = SIGNED != 0 && $signed(s1_data) < $signed(LO);
  assign sat = over || under;
  assign clamped = over ? HI[OUT_WIDTH-1:0] : under ? LO[OUT_WIDTH-1:0] : s1_data[OUT_WIDTH-1:0];
  // in-flight word in stage 1 reserves its FIFO slot, so the clamp stage never stalls
  assign din_ready = count + 3'(s1_valid) < 3'(FIFO_DEPTH);
  assign in_xfer = ena && din_valid && din_ready;
  assign dout_valid = count != 3'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      sat_flag <= 1'b0;
      drop_flag <= 1'b0;
    end else if (ena) begin
      s1_valid <= in_xfer;
      if (in_xfer) s1_data <= rnd;
      if (s1_valid && sat) sat_flag <= 1'b1;
      if (din_valid && !din_ready) drop_flag <= 1'b1;
    end
  end
`ifdef MATH_ROUND_SAT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) sat_count <= '0;
    else if (ena && s1_valid && sat && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
  end
`endif
  math_fifo_4 #(.W(OUT_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .push(s1_valid),
    .wdata(clamped),
    .pop(dout_ready),
    .rdata(dout),
    .count(count)
  );
endmodule

// File: tb/tb_math_round_sat_49.sv
// tb_math_round_sat_49: randomized + directed check of unsigned and signed instances against an arithmetic reference
module tb_math_round_sat_49;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic [48:0] din = '0;
  logic rdy_u, rdy_s, dv_u, dv_s, sf_u, sf_s, df_u, df_s;
  logic [31:0] do_u, do_s;
`ifdef MATH_ROUND_SAT_STATS_EN
  logic [15:0] sc_u, sc_s;
`endif
  typedef struct {
    logic [31:0] vu, vs;
    bit su, ss, seen;
    int tag;
  } word_t;
  word_t q[$];
  int en_cnt = 0, n_chk = 0, n_pass = 0, acc = 0, sc_mu = 0, sc_ms = 0;
  bit sat_u = 0, sat_s = 0, drop_m = 0;

  always #5 clk = ~clk;

  math_round_sat_49 #(.OUT_WIDTH(32), .SHIFT(16), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .din_valid(din_valid), .din_ready(rdy_u),
    .dout(do_u), .dout_valid(dv_u), .dout_ready(dout_ready), .sat_flag(sf_u), .drop_flag(df_u)
`ifdef MATH_ROUND_SAT_STATS_EN
    , .sat_count(sc_u)
`endif
  );
  math_round_sat_49 #(.OUT_WIDTH(32), .SHIFT(16), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .din_valid(din_valid), .din_ready(rdy_s),
    .dout(do_s), .dout_valid(dv_s), .dout_ready(dout_ready), .sat_flag(sf_s), .drop_flag(df_s)
`ifdef MATH_ROUND_SAT_STATS_EN
    , .sat_count(sc_s)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic word_t ref_word(input logic [48:0] d, input int tag);
    word_t w;
    longint u, s;
    u = (longint'(d) + 32768) / 65536;
    w.su = u > 64'sd4294967295;
    w.vu = w.su ? 32'hFFFF_FFFF : u[31:0];
    s = longint'({{16{d[47]}}, d[47:0]}) + 32768;
    s = s >= 0 ? s / 65536 : -((-s + 65535) / 65536);
    w.ss = s > 64'sd2147483647 || s < -64'sd2147483648;
    w.vs = s > 64'sd2147483647 ? 32'h7FFF_FFFF : s < -64'sd2147483648 ? 32'h8000_0000 : s[31:0];
    w.seen = 0;
    w.tag = tag;
    return w;
  endfunction

  function automatic logic [48:0] rnd_din();
    logic [48:0] b;
    case ($urandom_range(0, 3))
      0: b = 49'({$urandom, $urandom});
      1: b = 49'($urandom) << $urandom_range(0, 17);
      2: b = {1'($urandom), 48'(-(48'($urandom) << $urandom_range(0, 15)))};
      default: begin
        case ($urandom_range(0, 4))
          0: b = 49'h0_FFFF_FFFF_0000;
          1: b = 49'h1_0000_0000_0000;
          2: b = 49'h0_7FFF_FFFF_0000;
          3: b = 49'h0_8000_0000_0000;
          default: b = 49'h1_FFFF_8000_0000;
        endcase
        b = b + 49'($urandom_range(0, 65536)) - 49'd32768;
      end
    endcase
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ena = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;
    #1;
    chk("rst_din_ready_u", rdy_u, 1);
    chk("rst_din_ready_s", rdy_s, 1);
    chk("rst_dout_valid_u", dv_u, 0);
    chk("rst_dout_valid_s", dv_s, 0);
    chk("rst_dout_u", do_u, 0);
    chk("rst_sat_flag_u", sf_u, 0);
    chk("rst_drop_flag_u", df_u, 0);
    chk("rst_sat_flag_s", sf_s, 0);
    q.delete();
    sat_u = 0;
    sat_s = 0;
    drop_m = 0;
    sc_mu = 0;
    sc_ms = 0;
  endtask

  task automatic cycle(input bit v, input logic [48:0] d, input bit r, input bit e, input bit gate);
    bit rdy, vis;
    @(negedge clk);
    din_valid = gate ? v && rdy_u : v;
    din = d;
    dout_ready = r;
    ena = e;
    #1;
    rdy = q.size() < 4;
    chk("din_ready_u", rdy_u, rdy);
    chk("din_ready_s", rdy_s, rdy);
    foreach (q[i]) if (!q[i].seen && q[i].tag + 2 <= en_cnt) begin
      q[i].seen = 1;
      if (q[i].su) begin sat_u = 1; if (sc_mu < 65535) sc_mu++; end
      if (q[i].ss) begin sat_s = 1; if (sc_ms < 65535) sc_ms++; end
    end
    vis = q.size() > 0 && q[0].seen;
    chk("dout_valid_u", dv_u, vis);
    chk("dout_valid_s", dv_s, vis);
    chk("sat_flag_u", sf_u, sat_u);
    chk("sat_flag_s", sf_s, sat_s);
    chk("drop_flag_u", df_u, drop_m);
    chk("drop_flag_s", df_s, drop_m);
`ifdef MATH_ROUND_SAT_STATS_EN
    chk("sat_count_u", sc_u, sc_mu);
    chk("sat_count_s", sc_s, sc_ms);
`endif
    if (vis) begin
      chk("dout_u", do_u, q[0].vu);
      chk("dout_s", do_s, q[0].vs);
    end
    if (e) begin
      if (vis && r) void'(q.pop_front());
      if (din_valid) begin
        if (rdy) begin
          q.push_back(ref_word(d, en_cnt));
          acc++;
        end else drop_m = 1;
      end
      en_cnt++;
    end
  endtask

  initial begin
    do_reset();
    cycle(1, 49'h0_0000_0001_8000, 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
    chk("round_dout", do_u, 32'h2);
    chk("round_valid", dv_u, 1);
    chk("round_sat", sf_u, 0);
    cycle(1, 49'h1_0000_0000_0000, 1, 1, 0);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
    chk("ovf_dout", do_u, 32'hFFFF_FFFF);
    chk("ovf_sat", sf_u, 1);
`ifdef MATH_ROUND_SAT_STATS_EN
    chk("ovf_sat_count", sc_u, 1);
`endif
    cycle(1, 49'h0_8000_0000_0000, 1, 1, 0);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
    chk("neg_dout_s", do_s, 32'h8000_0000);
    cycle(0, '0, 1, 1, 0);
    do_reset();
    acc = 0;
    for (int i = 0; i < 8; i++) cycle(1, rnd_din(), 0, 1, 1);
    chk("bp_accepted", acc, 4);
    chk("bp_din_ready", rdy_u, 0);
    chk("bp_drop_flag", df_u, 0);
    cycle(1, rnd_din(), 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
    chk("drop_flag", df_u, 1);
    chk("drop_din_ready", rdy_u, 0);
    cycle(0, '0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, '0, 1, 1, 0);
    chk("drain_empty", dv_u, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, rnd_din(), 0, 1, 1);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 1, 0);
    chk("mid_buffered", dv_u, 1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      cycle($urandom % 4 != 0, rnd_din(), $urandom % 3 != 0, $urandom % 10 != 0, $urandom % 8 != 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
